// File: rtl/bus_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto a single shared bus with ack timeout.
// Define ARB_RR_EN to alternate grants under contention; otherwise the data port always wins.
module bus_arbiter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,

    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_sel_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,

    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,

    output logic        stallreq_o,
    output logic        bus_err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int              CNT_W  = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam bit              TO_EN  = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_gnt_mem;
    logic             r_bus_req;
    logic             r_bus_we;
    logic [31:0]      r_bus_addr;
    logic [31:0]      r_bus_wdata;
    logic [3:0]       r_bus_sel;
    logic [31:0]      r_if_rdata;
    logic [31:0]      r_mem_rdata;
    logic             r_if_ack;
    logic             r_mem_ack;
    logic             r_bus_err;

    logic             w_any_req;
    logic             w_grant_mem;
    logic             w_timeout;

    assign w_any_req = if_req_i | mem_req_i;

`ifdef ARB_RR_EN
    logic r_last_mem;

    // Under contention, hand the bus to whoever did not have it last time.
    assign w_grant_mem = mem_req_i & (~if_req_i | ~r_last_mem);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_mem <= 1'b0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_mem <= w_grant_mem;
        end
    end
`else
    assign w_grant_mem = mem_req_i;
`endif

    // r_cnt holds the number of BUSY cycles spent so far, including the current one.
    assign w_timeout = TO_EN && (r_cnt == TO_VAL) && !bus_ack_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_gnt_mem   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
            r_bus_sel   <= 4'h0;
            r_if_rdata  <= 32'h0;
            r_mem_rdata <= 32'h0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_if_ack  <= 1'b0;
                    r_mem_ack <= 1'b0;
                    r_bus_err <= 1'b0;
                    if (w_any_req) begin
                        r_state   <= S_BUSY;
                        r_bus_req <= 1'b1;
                        r_gnt_mem <= w_grant_mem;
                        r_cnt     <= CNT_W'(1);
                        if (w_grant_mem) begin
                            r_bus_we    <= mem_we_i;
                            r_bus_addr  <= mem_addr_i;
                            r_bus_wdata <= mem_wdata_i;
                            r_bus_sel   <= mem_sel_i;
                        end else begin
                            r_bus_we    <= 1'b0;
                            r_bus_addr  <= if_addr_i;
                            r_bus_wdata <= 32'h0;
                            r_bus_sel   <= 4'hF;
                        end
                    end
                end

                S_BUSY: begin
                    if (bus_ack_i) begin
                        r_state   <= S_RESP;
                        r_bus_req <= 1'b0;
                        r_if_ack  <= ~r_gnt_mem;
                        r_mem_ack <= r_gnt_mem;
                        if (r_gnt_mem) begin
                            r_mem_rdata <= bus_rdata_i;
                        end else begin
                            r_if_rdata  <= bus_rdata_i;
                        end
                    end else if (w_timeout) begin
                        r_state   <= S_RESP;
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_if_ack  <= ~r_gnt_mem;
                        r_mem_ack <= r_gnt_mem;
                        if (r_gnt_mem) begin
                            r_mem_rdata <= 32'h0;
                        end else begin
                            r_if_rdata  <= 32'h0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_RESP: begin
                    r_state   <= S_IDLE;
                    r_if_ack  <= 1'b0;
                    r_mem_ack <= 1'b0;
                    r_bus_err <= 1'b0;
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_bus_req <= 1'b0;
                    r_if_ack  <= 1'b0;
                    r_mem_ack <= 1'b0;
                    r_bus_err <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata_o  = r_if_rdata;
    assign if_ack_o    = r_if_ack;
    assign mem_rdata_o = r_mem_rdata;
    assign mem_ack_o   = r_mem_ack;
    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_bus_we;
    assign bus_addr_o  = r_bus_addr;
    assign bus_wdata_o = r_bus_wdata;
    assign bus_sel_o   = r_bus_sel;
    assign bus_err_o   = r_bus_err;

    // A requester stalls until its own completion pulse.
    assign stallreq_o  = (if_req_i & ~r_if_ack) | (mem_req_i & ~r_mem_ack);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random rounds against a transaction-level model.
module tb_bus_arbiter;

    localparam int TO = 4;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        stallreq_o;
    logic        bus_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level model state
    bit          m_last_mem;
    logic [31:0] m_if_rd;
    logic [31:0] m_mem_rd;

    bus_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_sel_i(mem_sel_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .stallreq_o(stallreq_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the following IDLE cycle.
    task automatic do_txn(input bit rq_if, input bit rq_mem, input logic [31:0] a_if,
                          input logic [31:0] a_mem, input bit we, input logic [31:0] wd,
                          input logic [3:0] sel, input int dly, input logic [31:0] rd,
                          output bit got_mem);
        bit          g_mem;
        bit          timed;
        bit          done;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_sel;
        bit          e_we;

        if_req_i = rq_if;  if_addr_i = a_if;
        mem_req_i = rq_mem; mem_addr_i = a_mem; mem_we_i = we; mem_wdata_i = wd; mem_sel_i = sel;
        g_mem  = rq_mem && (!rq_if || !RR || !m_last_mem);
        e_addr  = g_mem ? a_mem : a_if;
        e_we    = g_mem ? we : 1'b0;
        e_wdata = g_mem ? wd : 32'h0;
        e_sel   = g_mem ? sel : 4'hF;
        #1;
        check("idle_stall", stallreq_o, 1);
        check("idle_busreq", bus_req_o, 0);

        timed = 0;
        done  = 0;
        for (int k = 1; k <= TO && !done; k++) begin
            @(posedge clk); #1;
            check("busy_req", bus_req_o, 1);
            check("busy_addr", bus_addr_o, e_addr);
            check("busy_we", bus_we_o, e_we);
            check("busy_wdata", bus_wdata_o, e_wdata);
            check("busy_sel", bus_sel_o, e_sel);
            check("busy_acks", {if_ack_o, mem_ack_o, bus_err_o}, 0);
            check("busy_stall", stallreq_o, 1);
            // Request payloads are free to change while the bus is busy.
            if_addr_i   = $urandom;
            mem_addr_i  = $urandom;
            mem_wdata_i = $urandom;
            mem_we_i    = 1'($urandom);
            mem_sel_i   = 4'($urandom);
            bus_ack_i   = (k == dly);
            bus_rdata_i = (k == dly) ? rd : $urandom;
            timed = (k == TO) && (k != dly);
            done  = (k == dly) || (k == TO);
        end
        @(posedge clk); #1;
        bus_ack_i = 0;

        if (g_mem) m_mem_rd = timed ? 32'h0 : rd;
        else       m_if_rd  = timed ? 32'h0 : rd;
        m_last_mem = g_mem;
        got_mem = mem_ack_o;

        check("resp_if_ack", if_ack_o, !g_mem);
        check("resp_mem_ack", mem_ack_o, g_mem);
        check("resp_err", bus_err_o, timed);
        check("resp_busreq", bus_req_o, 0);
        check("resp_if_rdata", if_rdata_o, m_if_rd);
        check("resp_mem_rdata", mem_rdata_o, m_mem_rd);
        check("resp_stall", stallreq_o, g_mem ? rq_if : rq_mem);
        $display("txn if=%0b mem=%0b gnt=%s dly=%0d timeout=%0b addr=%h", rq_if, rq_mem,
                 g_mem ? "MEM" : "IF", dly, timed, e_addr);

        if (g_mem) mem_req_i = 0; else if_req_i = 0;
        @(posedge clk); #1;
        check("post_acks", {if_ack_o, mem_ack_o, bus_err_o}, 0);
        check("post_busreq", bus_req_o, 0);
        check("post_if_rdata", if_rdata_o, m_if_rd);
        check("post_mem_rdata", mem_rdata_o, m_mem_rd);
    endtask

    // A bus ack with nobody granted must have no effect.
    task automatic stray_ack();
        if_req_i = 0; mem_req_i = 0;
        bus_ack_i = 1; bus_rdata_i = $urandom;
        #1;
        check("stray_stall", stallreq_o, 0);
        @(posedge clk); #1;
        bus_ack_i = 0;
        check("stray_busreq", bus_req_o, 0);
        check("stray_acks", {if_ack_o, mem_ack_o, bus_err_o}, 0);
        check("stray_if_rdata", if_rdata_o, m_if_rd);
        check("stray_mem_rdata", mem_rdata_o, m_mem_rd);
        @(posedge clk); #1;
        check("stray_idle", bus_req_o, 0);
        $display("txn stray bus ack while idle");
    endtask

    // Fetch starts, reset pulses during BUSY; returns at posedge+1 of an IDLE cycle.
    task automatic reset_mid_busy();
        if_req_i = 1; if_addr_i = 32'h0000_0200; mem_req_i = 0;
        @(posedge clk); #1;
        check("rst_pre_busreq", bus_req_o, 1);
        rst = 0;
        #1;
        check("rst_busreq", bus_req_o, 0);
        check("rst_addr", bus_addr_o, 0);
        check("rst_acks", {if_ack_o, mem_ack_o, bus_err_o}, 0);
        check("rst_rdata", if_rdata_o | mem_rdata_o, 0);
        if_req_i = 0;
        m_last_mem = 0; m_if_rd = 0; m_mem_rd = 0;
        @(posedge clk); #3;
        rst = 1;
        @(posedge clk); #1;
        check("rst_after_acks", {if_ack_o, mem_ack_o, bus_err_o, bus_req_o}, 0);
        $display("txn reset during BUSY");
    endtask

    initial begin
        bit got;
        rst = 0;
        if_req_i = 0; if_addr_i = 0;
        mem_req_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_sel_i = 0;
        bus_ack_i = 0; bus_rdata_i = 0;
        m_last_mem = 0; m_if_rd = 0; m_mem_rd = 0;
        #1;
        check("reset_busreq", bus_req_o, 0);
        check("reset_bus", {bus_we_o, bus_sel_o} | bus_addr_o | bus_wdata_o, 0);
        check("reset_acks", {if_ack_o, mem_ack_o, bus_err_o}, 0);
        check("reset_rdata", if_rdata_o | mem_rdata_o, 0);
        @(posedge clk); #3;
        rst = 1;
        @(posedge clk); #1;

        // Single fetch, minimum latency
        do_txn(1, 0, 32'h0000_0100, 0, 0, 0, 0, 1, 32'h2401_0005, got);
        // Store with ack on third BUSY cycle
        do_txn(0, 1, 0, 32'h40, 1, 32'hDEAD_BEEF, 4'b0011, 3, 32'h1234_5678, got);
        // Timeout, then ack racing the timeout
        do_txn(1, 0, 32'h0000_0300, 0, 0, 0, 0, 0, 32'hAAAA_5555, got);
        do_txn(0, 1, 0, 32'h80, 0, 0, 4'hF, TO, 32'h0BAD_F00D, got);
        stray_ack();

        // Contention from a fresh reset so the alternation starts from IF-last
        reset_mid_busy();
        for (int i = 0; i < 4; i++) begin
            do_txn(1, 1, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 0, 0, 4'hF, 1, $urandom, got);
            check("contention_grant", got, RR ? (i % 2 == 0) : 1'b1);
        end
        if_req_i = 0; mem_req_i = 0;
        @(posedge clk); #1;

        reset_mid_busy();
        do_txn(1, 0, 32'h0000_0400, 0, 0, 0, 0, 2, 32'hCAFE_0001, got);

        for (int r = 0; r < 40; r++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                stray_ack();
            end else begin
                int rq;
                rq = $urandom_range(1, 3);
                do_txn(rq[0], rq[1], $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
                       $urandom_range(0, 5), $urandom, got);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
